imm_gen_stage: RTL and testbench

//  Registered immediate-generation stage between fetch and execute. Accepts one 32-bit

---
 rtl/imm_gen_stage_if.sv | 47 ++++
 rtl/imm_gen_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_stage_if.sv
// -----------------------------------------------------------------------------
// imm_gen_stage_if
// Handshake and data bundle for the immediate-generation stage.
//   in_valid/in_ready/in_inst/in_pc : upstream transfer into the stage
//   out_valid/out_ready/out_*       : head entry presented to execute
//   out_target (IMM_GEN_TARGET_EN)  : pc + imm for branch/jump/AUIPC
// Modports:
//   master : the environment around the stage (drives in_* and out_ready)
//   slave  : the stage itself
// Optional feature macro: IMM_GEN_TARGET_EN
// -----------------------------------------------------------------------------
interface imm_gen_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
`ifdef IMM_GEN_TARGET_EN
    logic [XLEN-1:0] out_target;
`endif

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt,
`ifdef IMM_GEN_TARGET_EN
               out_target,
`endif
               out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt,
`ifdef IMM_GEN_TARGET_EN
               out_target,
`endif
               out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
// Registered immediate-generation stage between fetch and execute. Decodes the
// instruction format and the XLEN sign-extended immediate, flags encodings that
// are illegal for XLEN, and holds results in a 2-entry skid buffer so in_ready
// depends only on the stage's own state.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (clears both entries and out_*)
//   flush  : synchronous flush, drops both entries and any push/pop this cycle
//   bus    : imm_gen_stage_if.slave (in_* handshake, out_* head entry)
// Optional feature macro: IMM_GEN_TARGET_EN adds out_target = out_pc + out_imm,
// computed before the buffer, for B/J formats and AUIPC (0 otherwise).
// out_fmt: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT
// -----------------------------------------------------------------------------
module imm_gen_stage #(
    parameter int XLEN = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_gen_stage_if.slave bus
);
    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_AMO      = 5'b01011;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP_32    = 5'b01110;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
`ifdef IMM_GEN_TARGET_EN
        logic [XLEN-1:0] target;
`endif
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Full decode of one instruction into a buffer entry. Illegal encodings
    // carry fmt NONE and a zero immediate so execute only has to look at the flag.
    function automatic entry_t decode_f(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        entry_t          e;
        logic            is_shift;
        logic            illegal;
        logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh, imm_shw;
        e        = '0;
        e.inst   = inst;
        e.pc     = pc;
        illegal  = 1'b0;
        is_shift = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);
        imm_i    = {{(XLEN-12){inst[31]}}, inst[31:20]};
        imm_s    = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
        imm_b    = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_j    = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        // Built at 64 bits then cut to XLEN, so XLEN=32 keeps the plain 32-bit value.
        imm_u    = XLEN'({{32{inst[31]}}, inst[31:12], 12'h000});
        imm_sh   = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
        imm_shw  = XLEN'(inst[24:20]);
        case (inst[6:2])
            OPC_LOAD, OPC_JALR: begin
                e.fmt = FMT_I;
                e.imm = imm_i;
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    illegal = (XLEN == 32) && inst[25];
                    e.fmt   = FMT_SHAMT;
                    e.imm   = imm_sh;
                end else begin
                    e.fmt = FMT_I;
                    e.imm = imm_i;
                end
            end
            OPC_OP_IMM32: begin
                if (XLEN == 32) begin
                    illegal = 1'b1;
                end else if (is_shift) begin
                    illegal = inst[25];
                    e.fmt   = FMT_SHAMT;
                    e.imm   = imm_shw;
                end else begin
                    e.fmt = FMT_I;
                    e.imm = imm_i;
                end
            end
            OPC_STORE: begin
                e.fmt = FMT_S;
                e.imm = imm_s;
            end
            OPC_BRANCH: begin
                e.fmt = FMT_B;
                e.imm = imm_b;
            end
            OPC_JAL: begin
                e.fmt = FMT_J;
                e.imm = imm_j;
            end
            OPC_LUI, OPC_AUIPC: begin
                e.fmt = FMT_U;
                e.imm = imm_u;
            end
            OPC_OP, OPC_MISC_MEM, OPC_SYSTEM, OPC_AMO: begin
                e.fmt = FMT_NONE;
            end
            OPC_OP_32: begin
                illegal = (XLEN == 32);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // Compressed or reserved low bits are never legal in this stage.
        illegal   = illegal | (inst[1:0] != 2'b11);
        e.illegal = illegal;
        if (illegal) begin
            e.fmt = FMT_NONE;
            e.imm = '0;
        end else begin
`ifdef IMM_GEN_TARGET_EN
            if ((e.fmt == FMT_B) || (e.fmt == FMT_J) || (inst[6:2] == OPC_AUIPC)) begin
                e.target = pc + e.imm;
            end else begin
                e.target = '0;
            end
`else
            e.fmt = e.fmt;
`endif
        end
        return e;
    endfunction

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;
    entry_t dec_s;
    logic   push_s;
    logic   pop_s;

    assign push_s = bus.in_valid & in_ready_q;
    assign pop_s  = out_valid_q & bus.out_ready;

    // Decode the word currently offered upstream.
    always_comb begin
        dec_s = decode_f(bus.in_inst, bus.in_pc);
    end

    // Skid-buffer next state: head is the FIFO front, tail only used in FULL.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        head_d  = dec_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        head_d = dec_s;
                    end else if (push_s) begin
                        tail_d  = dec_s;
                        state_d = ST_FULL;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State, entries and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_inst    = head_q.inst;
    assign bus.out_pc      = head_q.pc;
    assign bus.out_imm     = head_q.imm;
    assign bus.out_fmt     = head_q.fmt;
    assign bus.out_illegal = head_q.illegal;
`ifdef IMM_GEN_TARGET_EN
    assign bus.out_target  = head_q.target;
`endif
endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
// Drives an XLEN=64 and an XLEN=32 instance with identical traffic. A queue of
// accepted (inst, pc) pairs models the 2-entry buffer; expected head fields are
// re-derived from the decode rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;
    logic clk;
    logic rst_n;
    logic flush;

    imm_gen_stage_if #(.XLEN(64)) b64 ();
    imm_gen_stage_if #(.XLEN(32)) b32 ();

    imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));
    imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));

    assign b32.in_valid  = b64.in_valid;
    assign b32.in_inst   = b64.in_inst;
    assign b32.in_pc     = b64.in_pc[31:0];
    assign b32.out_ready = b64.out_ready;

    typedef struct {
        bit [31:0] inst;
        bit [63:0] pc;
    } txn_t;

    txn_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit [4:0] opcs [0:13] = '{5'b00000, 5'b00100, 5'b11001, 5'b00110, 5'b01000,
                              5'b11000, 5'b11011, 5'b01101, 5'b00101, 5'b01100,
                              5'b01110, 5'b00011, 5'b11100, 5'b01011};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the format rules.
    function automatic void ref_decode(input bit [31:0] inst, input int xlen, input bit [63:0] pc,
                                       output bit [2:0] fmt, output bit [63:0] imm,
                                       output bit ill, output bit [63:0] tgt);
        bit [4:0] opc;
        bit       shift;
        longint   v;
        opc   = inst[6:2];
        shift = (inst[14:12] == 3'd1) || (inst[14:12] == 3'd5);
        v     = 0;
        fmt   = 3'd0;
        ill   = 1'b0;
        case (opc)
            5'b00000, 5'b11001: begin fmt = 3'd1; v = longint'($signed(inst[31:20])); end
            5'b00100: begin
                if (shift) begin
                    fmt = 3'd6;
                    if (xlen == 32) begin ill = inst[25]; v = longint'(inst[24:20]); end
                    else v = longint'(inst[25:20]);
                end else begin
                    fmt = 3'd1; v = longint'($signed(inst[31:20]));
                end
            end
            5'b00110: begin
                if (xlen == 32) ill = 1'b1;
                else if (shift) begin fmt = 3'd6; ill = inst[25]; v = longint'(inst[24:20]); end
                else begin fmt = 3'd1; v = longint'($signed(inst[31:20])); end
            end
            5'b01000: begin fmt = 3'd2; v = longint'($signed({inst[31:25], inst[11:7]})); end
            5'b11000: begin fmt = 3'd3; v = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})); end
            5'b11011: begin fmt = 3'd5; v = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})); end
            5'b01101, 5'b00101: begin fmt = 3'd4; v = longint'($signed({inst[31:12], 12'h000})); end
            5'b01100, 5'b00011, 5'b11100, 5'b01011: fmt = 3'd0;
            5'b01110: ill = (xlen == 32);
            default: ill = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin fmt = 3'd0; v = 0; end
        imm = 64'(v);
        tgt = (!ill && (fmt == 3'd3 || fmt == 3'd5 || opc == 5'b00101)) ? pc + imm : 64'd0;
        if (xlen == 32) begin
            imm[63:32] = 32'd0;
            tgt[63:32] = 32'd0;
        end
    endfunction

    task automatic check_model();
        bit [2:0]  fmt;
        bit [63:0] imm, tgt, pc32;
        bit        ill;
        chk("in_ready64", 64'(b64.in_ready), 64'(q.size() != 2));
        chk("out_valid64", 64'(b64.out_valid), 64'(q.size() != 0));
        chk("in_ready32", 64'(b32.in_ready), 64'(q.size() != 2));
        chk("out_valid32", 64'(b32.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            ref_decode(q[0].inst, 64, q[0].pc, fmt, imm, ill, tgt);
            chk("inst64", 64'(b64.out_inst), 64'(q[0].inst));
            chk("pc64", b64.out_pc, q[0].pc);
            chk("imm64", b64.out_imm, imm);
            chk("fmt64", 64'(b64.out_fmt), 64'(fmt));
            chk("ill64", 64'(b64.out_illegal), 64'(ill));
`ifdef IMM_GEN_TARGET_EN
            chk("tgt64", b64.out_target, tgt);
`endif
            pc32 = {32'd0, q[0].pc[31:0]};
            ref_decode(q[0].inst, 32, pc32, fmt, imm, ill, tgt);
            chk("inst32", 64'(b32.out_inst), 64'(q[0].inst));
            chk("pc32", 64'(b32.out_pc), pc32);
            chk("imm32", 64'(b32.out_imm), imm);
            chk("fmt32", 64'(b32.out_fmt), 64'(fmt));
            chk("ill32", 64'(b32.out_illegal), 64'(ill));
`ifdef IMM_GEN_TARGET_EN
            chk("tgt32", 64'(b32.out_target), tgt);
`endif
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, check at the next falling edge.
    task automatic cycle(input bit v, input bit [31:0] inst, input bit [63:0] pc,
                         input bit ordy, input bit fl);
        bit   push, pop;
        txn_t t;
        b64.in_valid  = v;
        b64.in_inst   = inst;
        b64.in_pc     = pc;
        b64.out_ready = ordy;
        flush         = fl;
        push   = v && (q.size() < 2);
        pop    = ordy && (q.size() > 0);
        t.inst = inst;
        t.pc   = pc;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(t);
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic expect_head(input string tag, input bit [63:0] imm64, input bit [2:0] fmt64,
                               input bit ill64, input bit [31:0] imm32, input bit ill32);
        chk({tag, "_v64"}, 64'(b64.out_valid), 64'd1);
        chk({tag, "_imm64"}, b64.out_imm, imm64);
        chk({tag, "_fmt64"}, 64'(b64.out_fmt), 64'(fmt64));
        chk({tag, "_ill64"}, 64'(b64.out_illegal), 64'(ill64));
        chk({tag, "_v32"}, 64'(b32.out_valid), 64'd1);
        chk({tag, "_imm32"}, 64'(b32.out_imm), 64'(imm32));
        chk({tag, "_ill32"}, 64'(b32.out_illegal), 64'(ill32));
    endtask

    initial begin
        bit [31:0] rinst;
        bit [63:0] rpc;
        int        sel;

        rst_n         = 1'b0;
        flush         = 1'b0;
        b64.in_valid  = 1'b0;
        b64.in_inst   = 32'd0;
        b64.in_pc     = 64'd0;
        b64.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid64", 64'(b64.out_valid), 64'd0);
        chk("rst_imm64", b64.out_imm, 64'd0);
        chk("rst_inst64", 64'(b64.out_inst), 64'd0);
        chk("rst_pc64", b64.out_pc, 64'd0);
        chk("rst_fmt64", 64'(b64.out_fmt), 64'd0);
        chk("rst_ill64", 64'(b64.out_illegal), 64'd0);
        chk("rst_valid32", 64'(b32.out_valid), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(b64.in_ready), 64'd1);

        // Reference encodings, one per format of interest.
        cycle(1'b1, 32'hFFF00093, 64'h1000, 1'b1, 1'b0);
        expect_head("addi", 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        cycle(1'b1, 32'hFE000EE3, 64'h1000, 1'b1, 1'b0);
        expect_head("beq", 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 32'hFFFF_FFFC, 1'b0);
`ifdef IMM_GEN_TARGET_EN
        chk("beq_tgt64", b64.out_target, 64'hFFC);
`endif
        cycle(1'b1, 32'h02109093, 64'h2000, 1'b1, 1'b0);
        expect_head("slli33", 64'd33, 3'd6, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 32'h800000B7, 64'h2004, 1'b1, 1'b0);
        expect_head("lui", 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 32'h8000_0000, 1'b0);
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk("drain_valid", 64'(b64.out_valid), 64'd0);

        // Backpressure: A and B fill the buffer, C waits upstream.
        cycle(1'b1, 32'h00500093, 64'h100, 1'b0, 1'b0);
        chk("bp_ready_one", 64'(b64.in_ready), 64'd1);
        cycle(1'b1, 32'h00A00113, 64'h104, 1'b0, 1'b0);
        chk("bp_ready_full", 64'(b64.in_ready), 64'd0);
        cycle(1'b1, 32'h00F00193, 64'h108, 1'b0, 1'b0);
        chk("bp_hold_a", 64'(b64.out_inst), 64'h00500093);
        cycle(1'b1, 32'h00F00193, 64'h108, 1'b1, 1'b0);
        chk("bp_head_b", 64'(b64.out_inst), 64'h00A00113);
        cycle(1'b1, 32'h00F00193, 64'h108, 1'b1, 1'b0);
        chk("bp_head_c", 64'(b64.out_inst), 64'h00F00193);
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk("bp_empty", 64'(b64.out_valid), 64'd0);

        // Flush while FULL with a pending input.
        cycle(1'b1, 32'h00500093, 64'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h00A00113, 64'h204, 1'b0, 1'b0);
        cycle(1'b1, 32'h00F00193, 64'h208, 1'b0, 1'b1);
        chk("flush_valid", 64'(b64.out_valid), 64'd0);
        chk("flush_ready", 64'(b64.in_ready), 64'd1);

        // Asynchronous reset between clock edges with a live head entry.
        cycle(1'b1, 32'h00500093, 64'h300, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid64", 64'(b64.out_valid), 64'd0);
        chk("arst_imm64", b64.out_imm, 64'd0);
        chk("arst_valid32", 64'(b32.out_valid), 64'd0);
        chk("arst_imm32", 64'(b32.out_imm), 64'd0);
        q.delete();
        b64.in_valid = 1'b0;
        flush        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Random traffic over the interesting opcodes.
        for (int i = 0; i < 400; i++) begin
            rinst = $urandom;
            sel   = $urandom_range(0, 14);
            if (sel < 14) rinst[6:2] = opcs[sel];
            if ($urandom_range(0, 15) != 0) rinst[1:0] = 2'b11;
            rpc = {$urandom, $urandom};
            cycle($urandom_range(0, 3) != 0, rinst, rpc,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
        end
        repeat (3) cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
